rf_sweep_sched: RTL and testbench

- Sequences the sparse-kernel register-file builder over one feature map.
- Sweeps (h, w, s) coordinates and pulses the builder's start for each tuple, then waits for its finish.
- Presents each completed register file downstream with a valid/ready handshake before advancing to the next tuple.
- Sits between the top-level frame controller and the builder/MAC pair.

---
 rtl/rf_sweep_sched.sv | 196 +++++++++++++++++++
 tb/tb_rf_sweep_sched.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_sweep_sched.sv
// rf_sweep_sched
// Walks every (h, w, s) tuple of one feature map for the sparse-kernel
// register-file builder. For each tuple it pulses the builder start and waits
// for finish. It then offers the finished register file downstream with a
// valid/ready handshake before moving on to the next tuple.
//
// Ports
//   i_clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//   i_go                  sweep request, accepted only in IDLE
//   i_map_h/i_map_w/i_num_s  map height, map width, taps per position (latched on go)
//   o_start               one-cycle builder start
//   o_h/o_w/o_s           coordinates of the current tuple
//   i_finish              builder finish (level or pulse), looked at in WAIT only
//   o_rf_valid/i_rf_ready downstream handshake for the finished register file
//   o_busy                high in every state except IDLE
//   o_done                one-cycle end-of-sweep pulse
//   o_issued              tuples started in this sweep, saturating
//   o_err                 sticky watchdog error
//
// Optional feature: define RF_SWEEP_WATCHDOG_EN to bound WAIT to WD_CYC
// cycles. Without it, WAIT is unbounded and o_err is tied low.

module rf_sweep_sched #(
    parameter int H_W    = 7,
    parameter int W_W    = 7,
    parameter int S_W    = 3,
    parameter int CNT_W  = 17,
    parameter int WD_CYC = 1024
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_go,
    input  logic [H_W-1:0]   i_map_h,
    input  logic [W_W-1:0]   i_map_w,
    input  logic [S_W-1:0]   i_num_s,
    output logic             o_start,
    output logic [H_W-1:0]   o_h,
    output logic [W_W-1:0]   o_w,
    output logic [S_W-1:0]   o_s,
    input  logic             i_finish,
    output logic             o_rf_valid,
    input  logic             i_rf_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_issued,
    output logic             o_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_HAND,
        ST_DONE
    } state_t;

    localparam logic [H_W-1:0] H_ONE = {{(H_W-1){1'b0}}, 1'b1};
    localparam logic [W_W-1:0] W_ONE = {{(W_W-1){1'b0}}, 1'b1};
    localparam logic [S_W-1:0] S_ONE = {{(S_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state_q, state_d;

    logic [H_W-1:0]   h_q, map_h_q;
    logic [W_W-1:0]   w_q, map_w_q;
    logic [S_W-1:0]   s_q, num_s_q;
    logic [CNT_W-1:0] issued_q;

    logic sizes_ok;
    logic h_at_last, w_at_last, s_at_last, is_last;
    logic wd_expired;

    assign sizes_ok = (i_map_h != '0) && (i_map_w != '0) && (i_num_s != '0);

    // Compare against size-1 at coordinate width; zero sizes never reach here.
    assign h_at_last = (h_q == (map_h_q - H_ONE));
    assign w_at_last = (w_q == (map_w_q - W_ONE));
    assign s_at_last = (s_q == (num_s_q - S_ONE));
    assign is_last   = h_at_last && w_at_last && s_at_last;

`ifdef RF_SWEEP_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_CYC - 1);
    localparam logic [WD_W-1:0] WD_ONE  = {{(WD_W-1){1'b0}}, 1'b1};

    logic [WD_W-1:0] wd_cnt_q;
    logic            err_q;

    // Fires on the WD_CYC-th WAIT cycle that still has no finish.
    assign wd_expired = (state_q == ST_WAIT) && !i_finish && (wd_cnt_q == WD_LAST);

    // Watchdog counter is cleared in ISSUE, i.e. on every entry to WAIT.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE:  if (i_go) err_q <= 1'b0;
                ST_ISSUE: wd_cnt_q <= '0;
                ST_WAIT: begin
                    if (wd_expired) err_q <= 1'b1;
                    else if (!i_finish) wd_cnt_q <= wd_cnt_q + WD_ONE;
                end
                default: ;
            endcase
        end
    end

    assign o_err = err_q;
`else
    assign wd_expired = 1'b0;
    assign o_err      = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_go) state_d = sizes_ok ? ST_ISSUE : ST_DONE;
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (i_finish)        state_d = ST_HAND;
                else if (wd_expired) state_d = ST_DONE;
            end
            ST_HAND: begin
                if (i_rf_ready) state_d = is_last ? ST_DONE : ST_ISSUE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Sizes latch on an accepted go. Coordinates only move on the HAND
    // handshake, so they hold steady from ISSUE through HAND.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            map_h_q  <= '0;
            map_w_q  <= '0;
            num_s_q  <= '0;
            h_q      <= '0;
            w_q      <= '0;
            s_q      <= '0;
            issued_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_go) begin
                        map_h_q  <= i_map_h;
                        map_w_q  <= i_map_w;
                        num_s_q  <= i_num_s;
                        h_q      <= '0;
                        w_q      <= '0;
                        s_q      <= '0;
                        issued_q <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (issued_q != '1) issued_q <= issued_q + CNT_ONE;
                end
                ST_HAND: begin
                    if (i_rf_ready && !is_last) begin
                        if (s_at_last) begin
                            s_q <= '0;
                            if (w_at_last) begin
                                w_q <= '0;
                                h_q <= h_q + H_ONE;
                            end else begin
                                w_q <= w_q + W_ONE;
                            end
                        end else begin
                            s_q <= s_q + S_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_start    = (state_q == ST_ISSUE);
    assign o_rf_valid = (state_q == ST_HAND);
    assign o_busy     = (state_q != ST_IDLE);
    assign o_done     = (state_q == ST_DONE);
    assign o_h        = h_q;
    assign o_w        = w_q;
    assign o_s        = s_q;
    assign o_issued   = issued_q;

endmodule

// File: tb/tb_rf_sweep_sched.sv
// tb_rf_sweep_sched
// Directed bench for rf_sweep_sched. A small builder model answers every start
// with a finish three cycles later. Each start pulse is logged with its
// coordinates, and the log is compared against the tuple order the sweep
// should produce. The watchdog section is built only when
// RF_SWEEP_WATCHDOG_EN is defined.

module tb_rf_sweep_sched;

    localparam int H_W   = 7;
    localparam int W_W   = 7;
    localparam int S_W   = 3;
    localparam int CNT_W = 17;

    logic             i_clk = 1'b0;
    logic             i_rst_n;
    logic             i_go;
    logic [H_W-1:0]   i_map_h;
    logic [W_W-1:0]   i_map_w;
    logic [S_W-1:0]   i_num_s;
    logic             o_start;
    logic [H_W-1:0]   o_h;
    logic [W_W-1:0]   o_w;
    logic [S_W-1:0]   o_s;
    logic             i_finish;
    logic             o_rf_valid;
    logic             i_rf_ready;
    logic             o_busy;
    logic             o_done;
    logic [CNT_W-1:0] o_issued;
    logic             o_err;

    int checks   = 0;
    int failures = 0;

    logic [16:0] starts[$];
    int          done_cnt   = 0;
    bit          builder_on = 1'b0;

    rf_sweep_sched #(
        .H_W(H_W), .W_W(W_W), .S_W(S_W), .CNT_W(CNT_W), .WD_CYC(16)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_go(i_go),
        .i_map_h(i_map_h), .i_map_w(i_map_w), .i_num_s(i_num_s),
        .o_start(o_start), .o_h(o_h), .o_w(o_w), .o_s(o_s),
        .i_finish(i_finish), .o_rf_valid(o_rf_valid), .i_rf_ready(i_rf_ready),
        .o_busy(o_busy), .o_done(o_done), .o_issued(o_issued), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_start) starts.push_back({o_h, o_w, o_s});
        if (o_done)  done_cnt++;
    end

    // The builder model raises finish on the third falling edge after it sees
    // start, and holds it for one cycle.
    initial begin
        i_finish = 1'b0;
        forever begin
            @(negedge i_clk);
            if (builder_on && o_start) begin
                repeat (3) @(negedge i_clk);
                i_finish = 1'b1;
                @(negedge i_clk);
                i_finish = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    // Pulse go for one cycle, then scramble the size inputs to show they
    // were latched.
    task automatic applyStimulus(input int mh, input int mw, input int ms);
        @(negedge i_clk);
        i_map_h = H_W'(mh);
        i_map_w = W_W'(mw);
        i_num_s = S_W'(ms);
        i_go    = 1'b1;
        @(negedge i_clk);
        i_go    = 1'b0;
        i_map_h = 7'd5;
        i_map_w = 7'd5;
        i_num_s = 3'd5;
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (!o_done && n < budget) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_done) checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic checkSweep(input string tag, input int mh, input int mw, input int ms);
        int idx = 0;
        logic [16:0] exp_t;
        checkOutput({tag, "_starts"}, starts.size(), mh * mw * ms);
        for (int hh = 0; hh < mh; hh++)
            for (int ww = 0; ww < mw; ww++)
                for (int ss = 0; ss < ms; ss++) begin
                    exp_t = {7'(hh), 7'(ww), 3'(ss)};
                    if (idx < starts.size())
                        checkOutput({tag, "_tuple"}, 32'(starts[idx]), 32'(exp_t));
                    idx++;
                end
    endtask

    initial begin
        int n;
        int k;
        int d0;
        int s0;

        i_rst_n    = 1'b0;
        i_go       = 1'b0;
        i_map_h    = '0;
        i_map_w    = '0;
        i_num_s    = '0;
        i_rf_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge i_clk);
        checkOutput("rst_busy", o_busy, 0);
        checkOutput("rst_start", o_start, 0);
        checkOutput("rst_done", o_done, 0);
        checkOutput("rst_valid", o_rf_valid, 0);
        checkOutput("rst_issued", o_issued, 0);
        checkOutput("rst_h", o_h, 0);
        checkOutput("rst_w", o_w, 0);
        checkOutput("rst_s", o_s, 0);
        checkOutput("rst_err", o_err, 0);
        i_rst_n    = 1'b1;
        builder_on = 1'b1;

        // Basic 2x2x1 sweep
        starts.delete();
        applyStimulus(2, 2, 1);
        checkOutput("basic_start_latency", o_start, 1);
        waitDone(200);
        checkOutput("basic_issued", o_issued, 4);
        @(negedge i_clk);
        checkOutput("basic_busy_drop", o_busy, 0);
        checkOutput("basic_done_cnt", done_cnt, 1);
        checkSweep("basic", 2, 2, 1);

        // Tap wrap 1x2x3
        starts.delete();
        applyStimulus(1, 2, 3);
        waitDone(300);
        checkOutput("tap_issued", o_issued, 6);
        @(negedge i_clk);
        checkSweep("tap", 1, 2, 3);

        // Backpressure: hold ready low for five HAND cycles
        starts.delete();
        i_rf_ready = 1'b0;
        applyStimulus(1, 2, 1);
        n = 0;
        while (!o_rf_valid && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        checkOutput("bp_valid_seen", o_rf_valid, 1);
        for (int c = 0; c < 5; c++) begin
            checkOutput("bp_valid_hold", o_rf_valid, 1);
            checkOutput("bp_no_start", o_start, 0);
            checkOutput("bp_w_stable", o_w, 0);
            @(negedge i_clk);
        end
        checkOutput("bp_valid_last", o_rf_valid, 1);
        i_rf_ready = 1'b1;
        @(negedge i_clk);
        checkOutput("bp_valid_drop", o_rf_valid, 0);
        checkOutput("bp_next_start", o_start, 1);
        checkOutput("bp_next_w", o_w, 1);
        waitDone(200);
        @(negedge i_clk);
        checkSweep("bp", 1, 2, 1);

        // Degenerate size: num_s = 0
        s0 = starts.size();
        applyStimulus(3, 3, 0);
        checkOutput("degen_done", o_done, 1);
        checkOutput("degen_start", o_start, 0);
        checkOutput("degen_issued", o_issued, 0);
        checkOutput("degen_busy", o_busy, 1);
        @(negedge i_clk);
        checkOutput("degen_done_drop", o_done, 0);
        checkOutput("degen_idle", o_busy, 0);
        checkOutput("degen_no_starts", starts.size(), s0);

        // Reset during WAIT of tuple 3 of a 2x2x2 sweep
        applyStimulus(2, 2, 2);
        k = 0;
        n = 0;
        while (n < 200) begin
            if (o_start) k++;
            if (k == 3) break;
            @(negedge i_clk);
            n++;
        end
        checkOutput("rst3_reached", k, 3);
        checkOutput("rst3_w", o_w, 1);
        checkOutput("rst3_s", o_s, 0);
        @(negedge i_clk);
        checkOutput("rst3_issued", o_issued, 3);
        d0 = done_cnt;
        #2 i_rst_n = 1'b0;
        #1;
        checkOutput("arst_busy", o_busy, 0);
        checkOutput("arst_issued", o_issued, 0);
        checkOutput("arst_w", o_w, 0);
        checkOutput("arst_start", o_start, 0);
        checkOutput("arst_valid", o_rf_valid, 0);
        checkOutput("arst_done", o_done, 0);
        repeat (6) @(negedge i_clk);
        i_rst_n = 1'b1;
        checkOutput("arst_no_done", done_cnt, d0);

        // Restart after reset; a go during HAND must be ignored
        starts.delete();
        applyStimulus(1, 1, 2);
        checkOutput("restart_start", o_start, 1);
        checkOutput("restart_h", o_h, 0);
        checkOutput("restart_w", o_w, 0);
        checkOutput("restart_s", o_s, 0);
        @(negedge i_clk);
        checkOutput("restart_issued", o_issued, 1);
        n = 0;
        while (!o_rf_valid && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        checkOutput("restart_hand", o_rf_valid, 1);
        i_go = 1'b1;
        @(negedge i_clk);
        i_go = 1'b0;
        waitDone(200);
        checkOutput("busy_go_issued", o_issued, 2);
        @(negedge i_clk);
        checkSweep("restart", 1, 1, 2);

`ifdef RF_SWEEP_WATCHDOG_EN
        // Watchdog: builder never finishes
        builder_on = 1'b0;
        applyStimulus(1, 1, 1);
        n = 0;
        while (!o_err && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        checkOutput("wd_err_cycle", n, 17);
        checkOutput("wd_done", o_done, 1);
        checkOutput("wd_issued", o_issued, 1);
        @(negedge i_clk);
        checkOutput("wd_err_sticky", o_err, 1);
        applyStimulus(1, 1, 0);
        checkOutput("wd_err_clear", o_err, 0);
        @(negedge i_clk);
`else
        checkOutput("err_tied_low", o_err, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
